// File: rtl/traffic_phase_ctrl.sv
// Phase controller for a highway / side-road crossing.
// Drives the interval timer (enable_h, enable_n, start, timer_load), consumes its
// green (Timeout) and yellow (timeout) expiries, inserts all-red clearance and
// serves side-road requests latched from an asynchronous vehicle sensor.
module traffic_phase_ctrl #(
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CLR_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_req,
  input  logic       Timeout,
  input  logic       timeout,
  output logic       enable_h,
  output logic       enable_n,
  output logic       start,
  output logic       timer_load,
  output logic [2:0] hwy_light,
  output logic [2:0] side_light,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] HG  = 3'd0;
  localparam logic [2:0] HY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] SG  = 3'd3;
  localparam logic [2:0] SY  = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             load_flag;
  logic             load_nx;
  logic [CLR_W-1:0] clr_cnt;
  logic [CLR_W-1:0] clr_nx;
  logic             sync1;
  logic             req_s;
  logic             req_latched;
  logic             req_nx;
  logic             nx_is_ar;
  logic             cur_is_ar;

  // State, load flag, clearance counter, synchronizer and request latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HG;
      load_flag   <= 1'b1;
      clr_cnt     <= '0;
      sync1       <= 1'b0;
      req_s       <= 1'b0;
      req_latched <= 1'b0;
    end else begin
      state       <= state_nx;
      load_flag   <= load_nx;
      clr_cnt     <= clr_nx;
      sync1       <= car_req;
      req_s       <= sync1;
      req_latched <= req_nx;
    end
  end

  // Next-state logic; expiries are ignored while the timer is being reloaded.
  always_comb begin
    state_nx  = state;
    load_nx   = 1'b0;
    clr_nx    = clr_cnt;
    req_nx    = req_latched | req_s;
    nx_is_ar  = 1'b0;
    cur_is_ar = (state == AR1) || (state == AR2);

    case (state)
      HG: begin
        if (!load_flag && Timeout) begin
          if (req_latched) begin
            state_nx = HY;
          end else begin
            load_nx = 1'b1;  // highway rests in green: restart the green interval
          end
        end
      end
      HY:      if (!load_flag && timeout) state_nx = AR1;
      AR1:     if (clr_cnt == '0) state_nx = SG;
      SG:      if (!load_flag && Timeout) state_nx = SY;
      SY:      if (!load_flag && timeout) state_nx = AR2;
      AR2:     if (clr_cnt == '0) state_nx = HG;
      default: state_nx = AR2;
    endcase

    // Every fresh entry into a timed state restarts the timer.
    if ((state_nx != state) &&
        ((state_nx == HG) || (state_nx == HY) || (state_nx == SG) || (state_nx == SY))) begin
      load_nx = 1'b1;
    end

    // Clearance counter: load on entry to all-red, count down while there.
    nx_is_ar = (state_nx == AR1) || (state_nx == AR2);
    if (nx_is_ar && (state_nx != state)) begin
      clr_nx = CLR_LOAD;
    end else if (cur_is_ar && (clr_cnt != '0)) begin
      clr_nx = clr_cnt - CLR_W'(1);
    end

    // Serving the side road consumes the request; clear beats a concurrent set.
    if ((state_nx == SG) && (state != SG)) begin
      req_nx = 1'b0;
    end
  end

  // Moore decode of lights and timer controls from the state register.
  always_comb begin
    hwy_light  = LIGHT_R;
    side_light = LIGHT_R;
    enable_h   = 1'b0;
    enable_n   = 1'b0;
    start      = 1'b0;
    case (state)
      HG: begin
        hwy_light = LIGHT_G;
        enable_h  = 1'b1;
      end
      HY: begin
        hwy_light = LIGHT_Y;
        enable_h  = 1'b1;
        start     = 1'b1;
      end
      SG: begin
        side_light = LIGHT_G;
        enable_n   = 1'b1;
      end
      SY: begin
        side_light = LIGHT_Y;
        enable_n   = 1'b1;
        start      = 1'b1;
      end
      default: ;  // all-red and illegal codes keep both heads red
    endcase
  end

  // Load pulse is held off while reset is asserted.
  assign timer_load = load_flag & ~rst;
  assign state_dbg  = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with CLEAR_CYCLES = 4.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_req;
  logic       Timeout;
  logic       timeout;
  logic       enable_h;
  logic       enable_n;
  logic       start;
  logic       timer_load;
  logic [2:0] hwy_light;
  logic [2:0] side_light;
  logic [2:0] state_dbg;

  int total  = 0;
  int passed = 0;

  traffic_phase_ctrl #(.CLEAR_CYCLES(4), .CLR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .car_req    (car_req),
    .Timeout    (Timeout),
    .timeout    (timeout),
    .enable_h   (enable_h),
    .enable_n   (enable_n),
    .start      (start),
    .timer_load (timer_load),
    .hwy_light  (hwy_light),
    .side_light (side_light),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // State, both heads and the load pulse in one go.
  task automatic chk_st(input string tag, input logic [2:0] st, input logic [2:0] hw,
                        input logic [2:0] sd, input logic ld);
    chk({tag, ".state"}, 8'(state_dbg), 8'(st));
    chk({tag, ".hwy"}, 8'(hwy_light), 8'(hw));
    chk({tag, ".side"}, 8'(side_light), 8'(sd));
    chk({tag, ".load"}, 8'(timer_load), 8'(ld));
  endtask

  // Both greens must never be lit together.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("safety.greens", 8'(hwy_light[0] & side_light[0]), 8'd0);
    end
  end

  initial begin
    rst = 1'b1; car_req = 1'b0; Timeout = 1'b0; timeout = 1'b0;
    tick(); tick();
    // Reset state
    chk_st("rst", 3'd0, 3'b001, 3'b100, 1'b0);
    chk("rst.en_h", 8'(enable_h), 8'd1);
    chk("rst.en_n", 8'(enable_n), 8'd0);
    chk("rst.start", 8'(start), 8'd0);
    chk("rst.req", 8'(dut.req_latched), 8'd0);
    rst = 1'b0;
    #1;
    chk("rel.load", 8'(timer_load), 8'd1);
    tick();
    chk_st("hg.idle", 3'd0, 3'b001, 3'b100, 1'b0);

    // 1: no requests, highway rests in green and retriggers
    for (int k = 0; k < 2; k++) begin
      repeat (8) tick();
      Timeout = 1'b1;
      tick();
      Timeout = 1'b0;
      chk_st("rest.retrig", 3'd0, 3'b001, 3'b100, 1'b1);
      tick();
      chk("rest.load_off", 8'(timer_load), 8'd0);
    end

    // 3: request latches exactly as a retrigger fires; Timeout during load ignored
    car_req = 1'b1;
    tick(); tick();
    Timeout = 1'b1;
    tick();
    chk_st("stale.retrig", 3'd0, 3'b001, 3'b100, 1'b1);
    chk("stale.req", 8'(dut.req_latched), 8'd1);
    tick();
    Timeout = 1'b0;
    chk_st("stale.hold", 3'd0, 3'b001, 3'b100, 1'b0);

    // 4: yellow expiry in HG ignored
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk("hg.wrong", 8'(state_dbg), 8'd0);

    // 2: full cycle
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk_st("hy.entry", 3'd1, 3'b010, 3'b100, 1'b1);
    chk("hy.start", 8'(start), 8'd1);
    chk("hy.en_h", 8'(enable_h), 8'd1);
    tick();
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("hy.wrong", 8'(state_dbg), 8'd1);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk_st("ar1.c1", 3'd2, 3'b100, 3'b100, 1'b0);
    chk("ar1.en", 8'({enable_h, enable_n}), 8'd0);
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("ar1.c2", 8'(state_dbg), 8'd2);
    tick();
    chk("ar1.c3", 8'(state_dbg), 8'd2);
    tick();
    chk_st("ar1.c4", 3'd2, 3'b100, 3'b100, 1'b0);
    tick();
    // 6: request held through SG entry
    chk_st("sg.entry", 3'd3, 3'b100, 3'b001, 1'b1);
    chk("sg.en_n", 8'(enable_n), 8'd1);
    chk("sg.req_clr", 8'(dut.req_latched), 8'd0);
    tick();
    chk("sg.req_reset", 8'(dut.req_latched), 8'd1);
    car_req = 1'b0;
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk("sg.wrong", 8'(state_dbg), 8'd3);
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk_st("sy.entry", 3'd4, 3'b100, 3'b010, 1'b1);
    chk("sy.start", 8'(start), 8'd1);
    tick();
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("sy.wrong", 8'(state_dbg), 8'd4);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    chk_st("ar2.c1", 3'd5, 3'b100, 3'b100, 1'b0);
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("ar2.c2", 8'(state_dbg), 8'd5);
    tick();
    tick();
    chk("ar2.c4", 8'(state_dbg), 8'd5);
    tick();
    chk_st("hg.back", 3'd0, 3'b001, 3'b100, 1'b1);
    tick();
    Timeout = 1'b1;
    tick();
    Timeout = 1'b0;
    chk("hg.served_again", 8'(state_dbg), 8'd1);

    // 5: reset in SG
    car_req = 1'b1;
    tick();
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    repeat (4) tick();
    chk("r5.sg", 8'(state_dbg), 8'd3);
    tick();
    chk("r5.req_set", 8'(dut.req_latched), 8'd1);
    car_req = 1'b0;
    rst = 1'b1;
    tick();
    chk_st("r5.rst", 3'd0, 3'b001, 3'b100, 1'b0);
    chk("r5.req", 8'(dut.req_latched), 8'd0);
    rst = 1'b0;
    #1;
    chk("r5.load", 8'(timer_load), 8'd1);
    tick();
    chk_st("r5.after", 3'd0, 3'b001, 3'b100, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
